gray_sobel_frame_seq: RTL

Frame-level controller that sequences the grayscale/Sobel pixel pipeline. It accepts a frame request and mode from the host and latches the mode as the pipeline select for the whole frame. It issues the Sobel start pulse, gates the source pixel stream into the pipeline for exactly one frame, and counts pipeline outputs to report frame completion. It sits between the pixel source/host and the pipeline top, driving the pipeline's select, start and pixel-ready inputs.

---
 rtl/gray_sobel_pkg.sv | 37 +++
 rtl/seq_watchdog.sv | 45 ++++
 rtl/gray_sobel_frame_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gray_sobel_pkg.sv
// gray_sobel_pkg
// Shared types and helpers for the grayscale/Sobel frame sequencer.
//   seq_state_t        : frame sequencer states
//   pipe_mode_t        : pipeline select encoding
//   MAX_PIXEL_BITS     : source pixel width
//   PIXEL_WIDTH_OUT    : pipeline output pixel width
//   expected_out_count : pipeline outputs produced per frame for a given mode
package gray_sobel_pkg;

  localparam int MAX_PIXEL_BITS  = 8;
  localparam int PIXEL_WIDTH_OUT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    MODE_FULL   = 2'b00,
    MODE_SOBEL  = 2'b01,
    MODE_GRAY   = 2'b10,
    MODE_BYPASS = 2'b11
  } pipe_mode_t;

  // The 3x3 Sobel window drops a one-pixel border on every side.
  function automatic int expected_out_count(input pipe_mode_t mode, input int width,
                                            input int height);
    if (mode == MODE_FULL || mode == MODE_SOBEL) begin
      return (width - 2) * (height - 2);
    end
    return width * height;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog
// Down-counting timeout: reloads to LIMIT on clr_i, decrements on tick_i and
// flags expire_o on the tick that would take it to terminal count.
// Used by gray_sobel_frame_seq only when SEQ_TIMEOUT_EN is defined.
// Ports:
//   clk_i, nreset_i : clock, async active-low reset
//   clr_i           : reload counter
//   tick_i          : count one idle cycle
//   expire_o        : LIMIT consecutive ticks reached (combinational)
module seq_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LOAD = CW'(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (tick_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = tick_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/gray_sobel_frame_seq.sv
// gray_sobel_frame_seq
// Frame-level controller for the grayscale/Sobel pipeline: latches the mode
// per frame, pulses the Sobel start, gates exactly one frame of source pixels
// into the pipeline and counts pipeline outputs to signal completion.
// Optional DRAIN watchdog enabled by defining SEQ_TIMEOUT_EN.
// Ports:
//   clk_i, nreset_i            : clock, async active-low reset
//   frame_req_i, mode_i        : host frame request and mode
//   abort_i                    : synchronous frame abort
//   in_valid_i, in_pixel_i     : source pixel stream
//   in_ready_o                 : source pixel accept
//   pipe_rdy_i                 : pipeline output strobe
//   select_o, start_sobel_o    : pipeline control
//   px_rdy_o, pixel_o          : registered pixel to pipeline
//   busy_o, frame_done_o, err_o: status
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | waiting for frame_req_i, select_o holds last mode
// ST_START  | one cycle, Sobel start pulse for modes 00/01
// ST_STREAM | accepting source pixels until a full frame
// ST_DRAIN  | all pixels in, waiting for remaining outputs
// ST_DONE   | one-cycle frame_done_o
module gray_sobel_frame_seq
  import gray_sobel_pkg::*;
#(
  parameter int IMG_WIDTH     = 8,
  parameter int IMG_HEIGHT    = 8,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      frame_req_i,
  input  logic [1:0]                mode_i,
  input  logic                      abort_i,
  input  logic                      in_valid_i,
  input  logic [MAX_PIXEL_BITS-1:0] in_pixel_i,
  input  logic                      pipe_rdy_i,
  output logic                      in_ready_o,
  output logic [1:0]                select_o,
  output logic                      start_sobel_o,
  output logic                      px_rdy_o,
  output logic [MAX_PIXEL_BITS-1:0] pixel_o,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      err_o
);

  localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIX);

  seq_state_t                state_q, state_d;
  pipe_mode_t                select_q, select_d;
  logic [CNT_W-1:0]          in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]          exp_cnt;
  logic                      px_rdy_q, px_rdy_d;
  logic [MAX_PIXEL_BITS-1:0] pixel_q, pixel_d;
  logic                      in_accept;
  logic                      out_count;

  assign exp_cnt = CNT_W'(expected_out_count(select_q, IMG_WIDTH, IMG_HEIGHT));

`ifdef SEQ_TIMEOUT_EN
  logic err_q, err_d;
  logic wd_tick, wd_expire;

  // Any strobe or leaving DRAIN restarts the idle-cycle count.
  assign wd_tick = (state_q == ST_DRAIN) && !pipe_rdy_i;

  seq_watchdog #(
    .LIMIT(DRAIN_TIMEOUT)
  ) u_seq_watchdog (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .clr_i   (!wd_tick),
    .tick_i  (wd_tick),
    .expire_o(wd_expire)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    select_d  = select_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    px_rdy_d  = 1'b0;
    pixel_d   = pixel_q;
`ifdef SEQ_TIMEOUT_EN
    err_d     = err_q;
`endif

    // An aborted cycle never hands a pixel to the pipeline.
    in_accept = (state_q == ST_STREAM) && in_valid_i && !abort_i;
    // Strobes past the expected count are dropped so out_cnt saturates.
    out_count = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && pipe_rdy_i &&
                (out_cnt_q < exp_cnt);

    if (in_accept) begin
      in_cnt_d = in_cnt_q + 1'b1;
      px_rdy_d = 1'b1;
      pixel_d  = in_pixel_i;
    end
    if (out_count) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (frame_req_i) begin
          select_d  = pipe_mode_t'(mode_i);
          in_cnt_d  = '0;
          out_cnt_d = '0;
`ifdef SEQ_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          state_d   = ST_START;
        end
      end
      ST_START: state_d = ST_STREAM;
      ST_STREAM: begin
        // Outputs may already be complete at the last input; skip DRAIN then.
        if (in_cnt_d == FRAME_CNT) begin
          state_d = (out_cnt_d == exp_cnt) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_cnt_d == exp_cnt) begin
          state_d = ST_DONE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= ST_IDLE;
      select_q  <= MODE_FULL;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      px_rdy_q  <= 1'b0;
      pixel_q   <= '0;
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      px_rdy_q  <= px_rdy_d;
      pixel_q   <= pixel_d;
    end
  end

  assign in_ready_o    = (state_q == ST_STREAM);
  assign start_sobel_o = (state_q == ST_START) &&
                         ((select_q == MODE_FULL) || (select_q == MODE_SOBEL));
  assign busy_o        = (state_q != ST_IDLE);
  assign frame_done_o  = (state_q == ST_DONE);
  assign select_o      = select_q;
  assign px_rdy_o      = px_rdy_q;
  assign pixel_o       = pixel_q;

endmodule
